div_issue_sequencer: RTL and testbench

//   Upstream issue/retire stage for the sequential 32-bit divider core.
//   - Accepts a divide request over a valid/ready handshake and captures the operands.
//   - Converts signed operands to magnitudes and launches the core with a one-cycle start pulse.
//   - Waits for core completion, then applies sign correction and special-case results.
//   - Holds the result for the ALU result mux until it is accepted.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sign_fix.sv | 24 ++
 rtl/div_issue_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_div_issue_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue/retire path: sizes, timeout and
// the one-hot sequencer state encoding.
package div_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_TIMEOUT = 64;
  localparam logic [DIV_W-1:0] DIV_DZ_Q = {DIV_W{1'b1}};

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_WAIT   = 5'b00100,
    S_FIXUP  = 5'b01000,
    S_HOLD   = 5'b10000
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a pair of values; used both to
// form operand magnitudes and to restore signs on the core results.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             neg_a,
  input  logic             neg_b,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b
);

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  // Negation wraps within WIDTH, so the most negative value maps to itself.
  always_comb begin
    res_a = neg_a ? (ZERO_V - val_a) : val_a;
    res_b = neg_b ? (ZERO_V - val_b) : val_b;
  end

endmodule

// File: rtl/div_issue_sequencer.sv
// Issue/retire sequencer for the sequential divider core: captures requests,
// launches the core with operand magnitudes and returns sign-corrected results.
module div_issue_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_W,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sgn,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             core_start,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dz,
  output logic             rsp_to
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] x_r, q_cap_r, r_cap_r;
  logic             neg_q_r, neg_r_r, dz_r, ovf_r, to_r;
  logic             req_ready_r, core_start_r, rsp_valid_r, rsp_dz_r, rsp_to_r;
  logic [WIDTH-1:0] core_x_r, core_y_r, rsp_q_r, rsp_r_r;
  logic             accept_s, y_zero_s, ovf_s, expire_s;
  logic [WIDTH-1:0] mag_x_s, mag_y_s, sgn_q_s, sgn_r_s, fix_q_s, fix_r_s;

  div_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .val_a (req_x),
    .val_b (req_y),
    .neg_a (req_sgn & req_x[WIDTH-1]),
    .neg_b (req_sgn & req_y[WIDTH-1]),
    .res_a (mag_x_s),
    .res_b (mag_y_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .val_a (q_cap_r),
    .val_b (r_cap_r),
    .neg_a (neg_q_r),
    .neg_b (neg_r_r),
    .res_a (sgn_q_s),
    .res_b (sgn_r_s)
  );

  // Request decode and timeout detect; the counter runs from LAUNCH onward.
  always_comb begin
    accept_s = req_valid & req_ready_r;
    y_zero_s = (req_y == ZERO_V);
    ovf_s    = req_sgn & (req_x == MIN_V) & (req_y == ONES_V);
    expire_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  end

  // Next-state logic; core_done has priority over an expiring timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (y_zero_s | ovf_s) begin
            state_s = S_FIXUP;
          end else begin
            state_s = S_LAUNCH;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LAUNCH: state_s = S_WAIT;
      S_WAIT: begin
        if (core_done | expire_s) begin
          state_s = S_FIXUP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FIXUP: state_s = S_HOLD;
      S_HOLD: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Final result selection from the captured case flags.
  always_comb begin
    if (dz_r) begin
      fix_q_s = ONES_V;
      fix_r_s = x_r;
    end else if (ovf_r) begin
      fix_q_s = x_r;
      fix_r_s = ZERO_V;
    end else if (to_r) begin
      fix_q_s = ZERO_V;
      fix_r_s = ZERO_V;
    end else begin
      fix_q_s = sgn_q_s;
      fix_r_s = sgn_r_s;
    end
  end

  // State register and handshake/strobe outputs registered from next state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r      <= S_IDLE;
      req_ready_r  <= 1'b1;
      core_start_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == S_IDLE);
      core_start_r <= (state_s == S_LAUNCH);
      rsp_valid_r  <= (state_s == S_HOLD);
    end
  end

  // Operand capture, cycle counter, core result latch and response registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r    <= {CNT_W{1'b0}};
      x_r      <= ZERO_V;
      q_cap_r  <= ZERO_V;
      r_cap_r  <= ZERO_V;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      to_r     <= 1'b0;
      core_x_r <= ZERO_V;
      core_y_r <= ZERO_V;
      rsp_q_r  <= ZERO_V;
      rsp_r_r  <= ZERO_V;
      rsp_dz_r <= 1'b0;
      rsp_to_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            x_r     <= req_x;
            neg_q_r <= req_sgn & (req_x[WIDTH-1] ^ req_y[WIDTH-1]);
            neg_r_r <= req_sgn & req_x[WIDTH-1];
            dz_r    <= y_zero_s;
            ovf_r   <= ovf_s;
            to_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            if (!(y_zero_s | ovf_s)) begin
              core_x_r <= mag_x_s;
              core_y_r <= mag_y_s;
            end
          end
        end
        S_LAUNCH: cnt_r <= cnt_r + CNT_W'(1);
        S_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (core_done) begin
            q_cap_r <= core_q;
            r_cap_r <= core_r;
          end else if (expire_s) begin
            to_r <= 1'b1;
          end
        end
        S_FIXUP: begin
          rsp_q_r  <= fix_q_s;
          rsp_r_r  <= fix_r_s;
          rsp_dz_r <= dz_r;
          rsp_to_r <= to_r;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_dz_r <= 1'b0;
            rsp_to_r <= 1'b0;
          end
        end
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign core_start = core_start_r;
  assign core_x     = core_x_r;
  assign core_y     = core_y_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_q      = rsp_q_r;
  assign rsp_r      = rsp_r_r;
  assign rsp_dz     = rsp_dz_r;
  assign rsp_to     = rsp_to_r;

endmodule

// File: tb/tb_div_issue_sequencer.sv
// Directed self-checking bench for div_issue_sequencer with a simple
// behavioural divider core of programmable latency.
module tb_div_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_sgn = 1'b0;
  logic [31:0] req_x = 32'd0;
  logic [31:0] req_y = 32'd0;
  logic        core_done = 1'b0;
  logic [31:0] core_q = 32'd0;
  logic [31:0] core_r = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, core_start, rsp_valid, rsp_dz, rsp_to;
  logic [31:0] core_x, core_y, rsp_q, rsp_r;

  int   vectors = 0;
  int   miscompares = 0;
  logic core_en = 1'b1;
  int   core_lat = 4;
  int   core_rem = 0;
  int   lat;
  logic seen;

  div_issue_sequencer dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sgn    (req_sgn),
    .req_x      (req_x),
    .req_y      (req_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_done  (core_done),
    .core_q     (core_q),
    .core_r     (core_r),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_q      (rsp_q),
    .rsp_r      (rsp_r),
    .rsp_dz     (rsp_dz),
    .rsp_to     (rsp_to)
  );

  always #5 clk = ~clk;

  // Divider core model: done rises core_lat cycles after the start pulse and stays high.
  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      core_rem  <= core_en ? core_lat - 1 : 0;
      core_q    <= (core_y != 32'd0) ? core_x / core_y : 32'hFFFF_FFFF;
      core_r    <= (core_y != 32'd0) ? core_x % core_y : core_x;
    end else if (core_rem > 0) begin
      core_rem <= core_rem - 1;
      if (core_rem == 1) core_done <= 1'b1;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk1("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_sgn   = sgn;
    req_x     = x;
    req_y     = y;
    step();
    req_valid = 1'b0;
  endtask

  // Latency counts clock edges from the accept edge through the edge raising rsp_valid.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 200) begin
      step();
      l++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk1("rel_valid", rsp_valid, 1'b0);
    chk1("rel_ready", req_ready, 1'b1);
    chk1("rel_dz", rsp_dz, 1'b0);
    chk1("rel_to", rsp_to, 1'b0);
  endtask

  initial begin
    #1 rst_b = 1'b0;
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_core_start", core_start, 1'b0);
    chk32("rst_core_x", core_x, 32'd0);
    chk32("rst_core_y", core_y, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_q", rsp_q, 32'd0);
    chk32("rst_rsp_r", rsp_r, 32'd0);
    chk1("rst_dz", rsp_dz, 1'b0);
    chk1("rst_to", rsp_to, 1'b0);
    step();
    step();
    rst_b = 1'b1;
    step();

    // 1: unsigned 4802/172, core latency 34
    core_lat = 34;
    issue(1'b0, 32'd4802, 32'd172);
    chk1("t1_start", core_start, 1'b1);
    chk1("t1_busy", req_ready, 1'b0);
    chk32("t1_core_x", core_x, 32'd4802);
    chk32("t1_core_y", core_y, 32'd172);
    step();
    chk1("t1_start_once", core_start, 1'b0);
    wait_rsp(lat);
    lat++;
    chk32("t1_lat", lat, 32'd37);
    chk32("t1_q", rsp_q, 32'd27);
    chk32("t1_r", rsp_r, 32'd158);
    chk1("t1_dz", rsp_dz, 1'b0);
    chk1("t1_to", rsp_to, 1'b0);
    release_rsp();

    // 2: signed -7/2
    core_lat = 3;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk32("t2_core_x", core_x, 32'd7);
    chk32("t2_core_y", core_y, 32'd2);
    wait_rsp(lat);
    chk32("t2_lat", lat, 32'd6);
    chk32("t2_q", rsp_q, 32'hFFFF_FFFD);
    chk32("t2_r", rsp_r, 32'hFFFF_FFFF);
    release_rsp();

    // 3: divide by zero
    issue(1'b0, 32'd5, 32'd0);
    chk1("t3_no_start", core_start, 1'b0);
    wait_rsp(lat);
    chk32("t3_lat", lat, 32'd2);
    chk1("t3_no_start2", core_start, 1'b0);
    chk32("t3_q", rsp_q, 32'hFFFF_FFFF);
    chk32("t3_r", rsp_r, 32'd5);
    chk1("t3_dz", rsp_dz, 1'b1);
    release_rsp();

    // 4: signed overflow MIN / -1
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk1("t4_no_start", core_start, 1'b0);
    wait_rsp(lat);
    chk32("t4_lat", lat, 32'd2);
    chk32("t4_q", rsp_q, 32'h8000_0000);
    chk32("t4_r", rsp_r, 32'd0);
    chk1("t4_dz", rsp_dz, 1'b0);
    release_rsp();

    // 5: core never completes -> timeout
    core_en = 1'b0;
    issue(1'b0, 32'd100, 32'd7);
    wait_rsp(lat);
    chk32("t5_lat", lat, 32'd66);
    chk1("t5_to", rsp_to, 1'b1);
    chk32("t5_q", rsp_q, 32'd0);
    chk32("t5_r", rsp_r, 32'd0);
    release_rsp();

    // done arriving on the timeout cycle wins
    core_en  = 1'b1;
    core_lat = 63;
    issue(1'b0, 32'd1000, 32'd3);
    wait_rsp(lat);
    chk32("t5b_lat", lat, 32'd66);
    chk1("t5b_to", rsp_to, 1'b0);
    chk32("t5b_q", rsp_q, 32'd333);
    chk32("t5b_r", rsp_r, 32'd1);
    release_rsp();

    core_lat = 5;
    issue(1'b0, 32'd100, 32'd7);
    wait_rsp(lat);
    chk32("t5c_lat", lat, 32'd8);
    chk32("t5c_q", rsp_q, 32'd14);
    chk32("t5c_r", rsp_r, 32'd2);
    release_rsp();

    // 6: backpressure with a request held during HOLD, signed 9/-4
    core_lat = 4;
    issue(1'b1, 32'd9, 32'hFFFF_FFFC);
    chk32("t6_core_y", core_y, 32'd4);
    wait_rsp(lat);
    chk32("t6_lat", lat, 32'd7);
    req_valid = 1'b1;
    req_x     = 32'd123;
    req_y     = 32'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("t6_hold_valid", rsp_valid, 1'b1);
      chk1("t6_hold_ready", req_ready, 1'b0);
      chk32("t6_hold_q", rsp_q, 32'hFFFF_FFFE);
      chk32("t6_hold_r", rsp_r, 32'd1);
    end
    req_valid = 1'b0;
    release_rsp();

    // reset asserted while waiting on the core
    core_lat = 20;
    issue(1'b0, 32'd50, 32'd5);
    for (int i = 0; i < 5; i++) step();
    rst_b = 1'b0;
    #1;
    chk1("t7_req_ready", req_ready, 1'b1);
    chk1("t7_start", core_start, 1'b0);
    chk32("t7_core_x", core_x, 32'd0);
    chk32("t7_core_y", core_y, 32'd0);
    chk1("t7_valid", rsp_valid, 1'b0);
    step();
    step();
    rst_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen = seen | rsp_valid;
    end
    chk1("t7_no_rsp", seen, 1'b0);

    core_lat = 2;
    issue(1'b1, 32'hFFFF_FFEC, 32'd6);
    wait_rsp(lat);
    chk32("t8_lat", lat, 32'd5);
    chk32("t8_q", rsp_q, 32'hFFFF_FFFD);
    chk32("t8_r", rsp_r, 32'hFFFF_FFFE);
    release_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
